// File: rtl/if_ctrl_pkg.sv
// Shared types for the fetch-stage controller: PC source selects,
// exception vector selects, controller states and the redirect decision record.
package if_ctrl_pkg;

    typedef enum logic [2:0] {
        PC_BOOT = 3'd0,
        PC_JUMP = 3'd1,
        PC_EXC  = 3'd2,
        PC_ERET = 3'd3,
        PC_DRET = 3'd4,
        PC_BP   = 3'd5
    } pc_sel_e;

    typedef enum logic [1:0] {
        EXC_PC_EXC     = 2'd0,
        EXC_PC_IRQ     = 2'd1,
        EXC_PC_DBD     = 2'd2,
        EXC_PC_DBG_EXC = 2'd3
    } exc_pc_sel_e;

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_BOOT     = 3'd1,
        S_RUN      = 3'd2,
        S_REDIRECT = 3'd3,
        S_SLEEP    = 3'd4
    } if_ctrl_state_e;

    typedef struct packed {
        logic        valid;
        pc_sel_e     pc_sel;
        exc_pc_sel_e exc_sel;
    } redirect_t;

    localparam int unsigned BUBBLE_CNT_W = 4;

endpackage

// File: rtl/if_ctrl_if.sv
// Request/control bundle between the hazard/exception/debug logic and the
// fetch controller; master drives requests, slave is the controller.
interface if_ctrl_if import if_ctrl_pkg::*; ();

    logic           fetch_enable_i;
    logic           exc_req_i;
    logic           irq_i;
    logic           debug_req_i;
    logic           dret_req_i;
    logic           eret_req_i;
    logic           branch_taken_i;
    logic           wfi_i;
    logic           hazard_stall_i;
    logic           imem_ready_i;
    logic           pc_set_o;
    pc_sel_e        pc_mux_o;
    exc_pc_sel_e    exc_pc_mux_o;
    logic           stall_if_o;
    logic           flush_if_o;
    logic           fetch_en_o;
    if_ctrl_state_e state_o;

    modport master (
        output fetch_enable_i, exc_req_i, irq_i, debug_req_i, dret_req_i,
               eret_req_i, branch_taken_i, wfi_i, hazard_stall_i, imem_ready_i,
        input  pc_set_o, pc_mux_o, exc_pc_mux_o, stall_if_o, flush_if_o,
               fetch_en_o, state_o
    );

    modport slave (
        input  fetch_enable_i, exc_req_i, irq_i, debug_req_i, dret_req_i,
               eret_req_i, branch_taken_i, wfi_i, hazard_stall_i, imem_ready_i,
        output pc_set_o, pc_mux_o, exc_pc_mux_o, stall_if_o, flush_if_o,
               fetch_en_o, state_o
    );

endinterface

// File: rtl/if_ctrl.sv
// Fetch-stage controller: boots the PC, arbitrates redirects by priority,
// and issues the IF flush bubble and stall controls.
module if_ctrl
    import if_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    if_ctrl_if.slave  bus
);

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_LOAD = BUBBLE_CNT_W'(REDIRECT_BUBBLES - 1);

    if_ctrl_state_e          state_r;
    logic                    pc_set_r;
    pc_sel_e                 pc_mux_r;
    exc_pc_sel_e             exc_pc_mux_r;
    logic                    flush_r;
    logic [BUBBLE_CNT_W-1:0] cnt_r;
    redirect_t               redirect_s;
    logic                    acc_exc_s;
    logic                    acc_ret_s;
    logic                    acc_br_s;

    function automatic redirect_t redirect_prio(
        input logic exc, input logic irq, input logic dbg,
        input logic dret, input logic eret, input logic br
    );
        redirect_t r;
        r = '{valid: 1'b1, pc_sel: PC_EXC, exc_sel: EXC_PC_EXC};
        if (exc) begin
            r.exc_sel = EXC_PC_EXC;
        end else if (irq) begin
            r.exc_sel = EXC_PC_IRQ;
        end else if (dbg) begin
            r.exc_sel = EXC_PC_DBD;
        end else if (dret) begin
            r.pc_sel = PC_DRET;
        end else if (eret) begin
            r.pc_sel = PC_ERET;
        end else if (br) begin
            r.pc_sel = PC_JUMP;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

    // Which request classes each state may accept; branches only count on the live path.
    always_comb begin
        acc_exc_s = 1'b0;
        acc_ret_s = 1'b0;
        acc_br_s  = 1'b0;
        case (state_r)
            S_RUN: begin
                acc_exc_s = 1'b1;
                acc_ret_s = 1'b1;
                acc_br_s  = 1'b1;
            end
            S_REDIRECT: begin
                acc_exc_s = 1'b1;
                acc_ret_s = 1'b1;
            end
            S_SLEEP: begin
                acc_exc_s = 1'b1;
            end
            default: begin
                acc_exc_s = 1'b0;
            end
        endcase
        redirect_s = redirect_prio(bus.exc_req_i & acc_exc_s, bus.irq_i & acc_exc_s,
                                   bus.debug_req_i & acc_exc_s, bus.dret_req_i & acc_ret_s,
                                   bus.eret_req_i & acc_ret_s, bus.branch_taken_i & acc_br_s);
    end

    // Controller FSM with registered PC-load, mux select and flush outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_RESET;
            pc_set_r     <= 1'b0;
            pc_mux_r     <= PC_BOOT;
            exc_pc_mux_r <= EXC_PC_EXC;
            flush_r      <= 1'b0;
            cnt_r        <= {BUBBLE_CNT_W{1'b0}};
        end else begin
            pc_set_r <= 1'b0;
            if (redirect_s.valid) begin
                state_r  <= S_REDIRECT;
                pc_set_r <= 1'b1;
                pc_mux_r <= redirect_s.pc_sel;
                flush_r  <= 1'b1;
                cnt_r    <= BUBBLE_LOAD;
                // Vector select is only meaningful for exception-class redirects.
                if (redirect_s.pc_sel == PC_EXC) begin
                    exc_pc_mux_r <= redirect_s.exc_sel;
                end
            end else begin
                case (state_r)
                    S_RESET: begin
                        if (bus.fetch_enable_i) begin
                            state_r  <= S_BOOT;
                            pc_set_r <= 1'b1;
                            pc_mux_r <= PC_BOOT;
                        end
                    end
                    S_BOOT: begin
                        state_r <= S_RUN;
                    end
                    S_RUN: begin
                        if (bus.wfi_i) begin
                            state_r <= S_SLEEP;
                        end
                    end
                    S_REDIRECT: begin
                        if (cnt_r == {BUBBLE_CNT_W{1'b0}}) begin
                            state_r <= S_RUN;
                            flush_r <= 1'b0;
                        end else begin
                            cnt_r   <= cnt_r - {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
                            flush_r <= 1'b1;
                        end
                    end
                    S_SLEEP: begin
                        state_r <= S_SLEEP;
                    end
                    default: begin
                        state_r <= S_RESET;
                        flush_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pc_set_o     = pc_set_r;
    assign bus.pc_mux_o     = pc_mux_r;
    assign bus.exc_pc_mux_o = exc_pc_mux_r;
    assign bus.flush_if_o   = flush_r;
    assign bus.state_o      = state_r;
    assign bus.fetch_en_o   = (state_r == S_BOOT) | (state_r == S_RUN) | (state_r == S_REDIRECT);
    // A PC load always beats a stall so the redirect target is never held off.
    assign bus.stall_if_o   = (state_r == S_RUN) & (bus.hazard_stall_i | ~bus.imem_ready_i) & ~pc_set_r;

endmodule
